// File: rtl/qpsk_symbol_strobe.sv
// QPSK symbol timing: divides CIC output pulses into symbol periods, emits symbol and
// mid-symbol strobes, and slips phase by one CIC sample from an accumulated timing error.
module qpsk_symbol_strobe #(
    parameter int SPS       = 16,
    parameter int ERR_W     = 16,
    parameter int ACC_W     = 20,
    parameter int THRESH    = 4096,
    parameter int LOCK_SYMS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     cic_40_pulse,
    input  logic [15:0]              cic_pulse_counter,
    input  logic                     err_valid,
    input  logic signed [ERR_W-1:0]  timing_err,
    output logic                     symbol_strobe,
    output logic                     mid_strobe,
    output logic [$clog2(SPS)-1:0]   sample_phase,
    output logic [15:0]              symbol_count,
    output logic [15:0]              pulse_stamp,
    output logic                     adj_early,
    output logic                     adj_late,
    output logic                     locked
);

    localparam int PW = $clog2(SPS);
    localparam int LW = $clog2(LOCK_SYMS + 1);

    localparam logic [PW-1:0] PH_LAST  = PW'(SPS - 1);
    localparam logic [PW-1:0] PH_MID   = PW'(SPS / 2 - 1);
    localparam logic [PW-1:0] PH_EARLY = PW'(2);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_SYMS);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] POS_TH  = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] NEG_TH  = ACC_W'(-THRESH);

    logic                    en_q;
    logic                    adj_seen;
    logic [LW-1:0]           lock_cnt;
    logic signed [ACC_W-1:0] acc;

    logic                    run;
    logic                    hit_sym;
    logic                    hit_mid;
    logic                    do_late;
    logic                    do_early;
    logic signed [ACC_W-1:0] err_ext;
    logic [ACC_W:0]          acc_sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [PW-1:0]           phase_nxt;

    // The first enabled edge only arms en_q, so a pulse coincident with enable rising is dropped.
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        run       = enable && en_q;
        hit_sym   = run && cic_40_pulse && (sample_phase == PH_LAST);
        hit_mid   = run && cic_40_pulse && (sample_phase == PH_MID);
        do_late   = run && cic_40_pulse && (sample_phase == '0) && (acc >= POS_TH);
        do_early  = run && cic_40_pulse && (sample_phase == '0) && (acc <= NEG_TH);
        err_ext   = ACC_W'(timing_err);
        acc_sum   = {acc[ACC_W-1], acc} + {err_ext[ACC_W-1], err_ext};
        acc_nxt   = acc;
        phase_nxt = sample_phase;

        if (do_late || do_early) begin
            acc_nxt = err_valid ? err_ext : '0;
        end else if (run && err_valid) begin
            if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
                acc_nxt = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_nxt = acc_sum[ACC_W-1:0];
            end
        end

        if (do_late) begin
            phase_nxt = '0;
        end else if (do_early) begin
            phase_nxt = PH_EARLY;
        end else if (run && cic_40_pulse) begin
            phase_nxt = (sample_phase == PH_LAST) ? '0 : sample_phase + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            adj_seen      <= 1'b0;
            lock_cnt      <= '0;
            acc           <= '0;
            sample_phase  <= '0;
            symbol_count  <= '0;
            pulse_stamp   <= '0;
            symbol_strobe <= 1'b0;
            mid_strobe    <= 1'b0;
            adj_early     <= 1'b0;
            adj_late      <= 1'b0;
        end else if (!enable) begin
            en_q          <= 1'b0;
            adj_seen      <= 1'b0;
            lock_cnt      <= '0;
            acc           <= '0;
            sample_phase  <= '0;
            symbol_count  <= '0;
            pulse_stamp   <= '0;
            symbol_strobe <= 1'b0;
            mid_strobe    <= 1'b0;
            adj_early     <= 1'b0;
            adj_late      <= 1'b0;
        end else begin
            en_q          <= 1'b1;
            symbol_strobe <= hit_sym;
            mid_strobe    <= hit_mid;
            adj_late      <= do_late;
            adj_early     <= do_early;
            acc           <= acc_nxt;
            sample_phase  <= phase_nxt;

            if (hit_sym) begin
                symbol_count <= symbol_count + 16'd1;
                pulse_stamp  <= cic_pulse_counter;
            end

            // adj_seen remembers an adjust inside the current symbol so its strobe does not count toward lock.
            if (do_late || do_early) begin
                lock_cnt <= '0;
                adj_seen <= 1'b1;
            end else if (hit_sym) begin
                adj_seen <= 1'b0;
                if (!adj_seen && lock_cnt != LOCK_MAX) begin
                    lock_cnt <= lock_cnt + LW'(1);
                end
            end
        end
    end

    assign locked = (lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_qpsk_symbol_strobe.sv
// Bench for qpsk_symbol_strobe: a behavioural model predicts every cycle's outputs into a
// scoreboard queue, and scenario tasks add targeted timing checks on strobes and adjusts.
module tb_qpsk_symbol_strobe;

    localparam int SPS       = 16;
    localparam int ERR_W     = 16;
    localparam int ACC_W     = 20;
    localparam int THRESH    = 4096;
    localparam int LOCK_SYMS = 32;
    localparam int PW        = $clog2(SPS);
    localparam int ACC_MAX   = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN   = -(1 << (ACC_W - 1));

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable = 1'b0;
    logic                    cic_40_pulse = 1'b0;
    logic [15:0]             cic_pulse_counter = '0;
    logic                    err_valid = 1'b0;
    logic signed [ERR_W-1:0] timing_err = '0;
    logic                    symbol_strobe;
    logic                    mid_strobe;
    logic [PW-1:0]           sample_phase;
    logic [15:0]             symbol_count;
    logic [15:0]             pulse_stamp;
    logic                    adj_early;
    logic                    adj_late;
    logic                    locked;

    qpsk_symbol_strobe #(
        .SPS(SPS), .ERR_W(ERR_W), .ACC_W(ACC_W), .THRESH(THRESH), .LOCK_SYMS(LOCK_SYMS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cic_40_pulse(cic_40_pulse),
        .cic_pulse_counter(cic_pulse_counter), .err_valid(err_valid), .timing_err(timing_err),
        .symbol_strobe(symbol_strobe), .mid_strobe(mid_strobe), .sample_phase(sample_phase),
        .symbol_count(symbol_count), .pulse_stamp(pulse_stamp), .adj_early(adj_early),
        .adj_late(adj_late), .locked(locked)
    );

    always #40 clk = ~clk;

    typedef struct {
        bit sym; bit mid; bit late; bit early; bit lck;
        int phase; int cnt; int stamp;
    } exp_t;

    typedef struct {
        int pidx; int cyc; bit lck; int cnt; int stamp; int want_stamp;
    } obs_t;

    exp_t sb[$];
    obs_t sym_log[$];
    int   mid_log[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int p_idx = 0;
    int first_mid_pidx = -1;
    int n_late = 0, late_pidx = 0, late_phase = 0;
    bit late_lock = 1'b0;
    int n_early = 0, early_pidx = 0, early_phase = 0, early_cyc = 0;

    int m_phase = 0, m_acc = 0, m_lock = 0, m_count = 0, m_stamp = 0;
    bit m_adj_seen = 1'b0, m_en_q = 1'b0;

    function automatic logic [15:0] stamp_of(input int i);
        return 16'(i * 7 + 3);
    endfunction

    // Model of one clock edge using the inputs currently driven.
    function automatic exp_t model_edge();
        exp_t e;
        bit run, dl, de, hs, hm;
        int sum;
        e.sym = 0; e.mid = 0; e.late = 0; e.early = 0;
        if (!rst_n || !enable) begin
            m_phase = 0; m_acc = 0; m_lock = 0; m_count = 0; m_stamp = 0;
            m_adj_seen = 0; m_en_q = 0;
        end else begin
            run = m_en_q;
            m_en_q = 1;
            dl = run && cic_40_pulse && m_phase == 0 && m_acc >= THRESH;
            de = run && cic_40_pulse && m_phase == 0 && m_acc <= -THRESH;
            hs = run && cic_40_pulse && m_phase == SPS - 1;
            hm = run && cic_40_pulse && m_phase == SPS / 2 - 1;
            if (dl || de) begin
                m_acc = err_valid ? int'(timing_err) : 0;
            end else if (run && err_valid) begin
                sum = m_acc + int'(timing_err);
                m_acc = (sum > ACC_MAX) ? ACC_MAX : (sum < ACC_MIN) ? ACC_MIN : sum;
            end
            if (run && cic_40_pulse) m_phase = dl ? 0 : de ? 2 : (m_phase + 1) % SPS;
            if (hs) begin
                m_count = (m_count + 1) % 65536;
                m_stamp = int'(cic_pulse_counter);
            end
            if (dl || de) begin
                m_lock = 0;
                m_adj_seen = 1;
            end else if (hs) begin
                if (!m_adj_seen && m_lock < LOCK_SYMS) m_lock++;
                m_adj_seen = 0;
            end
            e.sym = hs; e.mid = hm; e.late = dl; e.early = de;
        end
        e.phase = m_phase; e.cnt = m_count; e.stamp = m_stamp; e.lck = (m_lock == LOCK_SYMS);
        return e;
    endfunction

    task automatic cycle(input bit p, input bit ev, input int err);
        exp_t w;
        obs_t o;
        cic_40_pulse = p;
        err_valid    = ev;
        timing_err   = ERR_W'(err);
        if (p) begin
            p_idx++;
            cic_pulse_counter = stamp_of(p_idx);
        end
        sb.push_back(model_edge());
        @(posedge clk);
        #1;
        cyc++;
        w = sb.pop_front();
        checks++;
        if (symbol_strobe !== w.sym || mid_strobe !== w.mid || adj_late !== w.late ||
            adj_early !== w.early || locked !== w.lck || sample_phase !== PW'(w.phase) ||
            symbol_count !== 16'(w.cnt) || pulse_stamp !== 16'(w.stamp)) begin
            failures++;
            if (failures <= 20)
                $display("FAIL cycle_%0d: got sym=%b mid=%b late=%b early=%b lock=%b ph=%0d cnt=%h stamp=%h; want sym=%b mid=%b late=%b early=%b lock=%b ph=%0d cnt=%h stamp=%h",
                         cyc, symbol_strobe, mid_strobe, adj_late, adj_early, locked, sample_phase,
                         symbol_count, pulse_stamp, w.sym, w.mid, w.late, w.early, w.lck, w.phase,
                         16'(w.cnt), 16'(w.stamp));
        end
        if (symbol_strobe === 1'b1) begin
            o.pidx = p_idx; o.cyc = cyc; o.lck = locked; o.cnt = int'(symbol_count);
            o.stamp = int'(pulse_stamp); o.want_stamp = int'(stamp_of(p_idx));
            sym_log.push_back(o);
        end
        if (mid_strobe === 1'b1) begin
            mid_log.push_back(cyc);
            if (first_mid_pidx < 0) first_mid_pidx = p_idx;
        end
        if (adj_late === 1'b1) begin
            n_late++; late_pidx = p_idx; late_phase = int'(sample_phase); late_lock = locked;
        end
        if (adj_early === 1'b1) begin
            n_early++; early_pidx = p_idx; early_phase = int'(sample_phase); early_cyc = cyc;
        end
    endtask

    // One pulse followed by nerr error cycles, padded with idle cycles to the given spacing.
    task automatic pulse_err(input int spacing, input int nerr, input int err);
        cycle(1'b1, 1'b0, 0);
        repeat (nerr) cycle(1'b0, 1'b1, err);
        repeat (spacing - 1 - nerr) cycle(1'b0, 1'b0, 0);
    endtask

    task automatic advance_to(input int ph, input int spacing);
        for (int i = 0; i < 2 * SPS && m_phase != ph; i++) pulse_err(spacing, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (400) cycle(1'b0, 1'b0, 0);
        checks++;
        if ({symbol_strobe, mid_strobe, adj_early, adj_late, locked} !== 5'b0 ||
            sample_phase !== '0 || symbol_count !== '0 || pulse_stamp !== '0) begin
            failures++;
            $display("FAIL reset_state: ph=%0d cnt=%h stamp=%h flags=%b, want all zero",
                     sample_phase, symbol_count, pulse_stamp,
                     {symbol_strobe, mid_strobe, adj_early, adj_late, locked});
        end
    endtask

    task automatic test_nominal();
        rst_n = 1'b1;
        enable = 1'b1;
        p_idx = 0;
        sym_log.delete();
        mid_log.delete();
        cycle(1'b0, 1'b0, 0);
        repeat (2 * SPS) pulse_err(320, 0, 0);
        checks++;
        if (sym_log.size() != 2 || sym_log[0].pidx != SPS) begin
            failures++;
            $display("FAIL nominal_first_strobe: strobes=%0d first_pulse=%0d, want 2 and %0d",
                     sym_log.size(), (sym_log.size() > 0) ? sym_log[0].pidx : -1, SPS);
        end
        checks++;
        if (sym_log.size() == 2 && sym_log[1].cyc - sym_log[0].cyc != 5120) begin
            failures++;
            $display("FAIL nominal_period: %0d clk, want 5120", sym_log[1].cyc - sym_log[0].cyc);
        end
        checks++;
        if (first_mid_pidx != SPS / 2 || mid_log.size() != 2 || mid_log[1] - mid_log[0] != 5120) begin
            failures++;
            $display("FAIL nominal_mid: first_pulse=%0d mids=%0d, want %0d and 2 spaced 5120",
                     first_mid_pidx, mid_log.size(), SPS / 2);
        end
        repeat ((LOCK_SYMS - 2) * SPS) pulse_err(4, 0, 0);
        checks++;
        if (sym_log.size() != LOCK_SYMS || sym_log[LOCK_SYMS-2].lck !== 1'b0 ||
            sym_log[LOCK_SYMS-1].lck !== 1'b1 || sym_log[LOCK_SYMS-1].cnt != LOCK_SYMS) begin
            failures++;
            $display("FAIL nominal_lock: strobes=%0d, want lock rising exactly at strobe %0d",
                     sym_log.size(), LOCK_SYMS);
        end
    endtask

    task automatic test_late_adjust();
        int n0, s0;
        advance_to(SPS - 1, 320);
        pulse_err(320, 1, THRESH);
        n0 = n_late;
        s0 = sym_log.size();
        pulse_err(320, 0, 0);
        checks++;
        if (n_late != n0 + 1 || late_phase != 0 || late_lock !== 1'b0 ||
            late_pidx != sym_log[s0-1].pidx + 1) begin
            failures++;
            $display("FAIL late_adjust: adjusts=%0d phase=%0d lock=%b, want 1 adjust, phase 0, unlocked",
                     n_late - n0, late_phase, late_lock);
        end
        advance_to(SPS - 1, 320);
        pulse_err(320, 0, 0);
        checks++;
        if (sym_log.size() != s0 + 1 || sym_log[s0].pidx - sym_log[s0-1].pidx != SPS + 1 ||
            sym_log[s0].cyc - sym_log[s0-1].cyc != 5440 || sym_log[s0].lck !== 1'b0) begin
            failures++;
            $display("FAIL late_period: strobes=%0d gap=%0d clk, want 1 strobe 5440 clk later",
                     sym_log.size() - s0, sym_log[sym_log.size()-1].cyc - sym_log[s0-1].cyc);
        end
    endtask

    task automatic test_early_adjust();
        int n0, s0;
        advance_to(SPS - 1, 320);
        pulse_err(320, 2, -THRESH / 2);
        n0 = n_early;
        s0 = sym_log.size();
        pulse_err(320, 0, 0);
        checks++;
        if (n_early != n0 + 1 || early_phase != 2) begin
            failures++;
            $display("FAIL early_adjust: adjusts=%0d phase=%0d, want 1 and 2", n_early - n0, early_phase);
        end
        advance_to(SPS - 1, 320);
        pulse_err(320, 0, 0);
        checks++;
        if (sym_log.size() != s0 + 1 || sym_log[s0].pidx - early_pidx != 14 ||
            sym_log[s0].cyc - early_cyc != 4480) begin
            failures++;
            $display("FAIL early_period: strobes=%0d gap=%0d clk, want 1 strobe 4480 clk after adjust",
                     sym_log.size() - s0, sym_log[sym_log.size()-1].cyc - early_cyc);
        end
    endtask

    task automatic test_saturation();
        int n0;
        repeat (20) cycle(1'b0, 1'b1, 32767);
        checks++;
        if (int'(dut.acc) != ACC_MAX) begin
            failures++;
            $display("FAIL acc_saturate: acc=%0d, want %0d", int'(dut.acc), ACC_MAX);
        end
        advance_to(0, 4);
        n0 = n_late;
        cycle(1'b1, 1'b1, -100);
        checks++;
        if (n_late != n0 + 1 || int'(dut.acc) != -100) begin
            failures++;
            $display("FAIL acc_coincide: adjusts=%0d acc=%0d, want 1 and -100", n_late - n0, int'(dut.acc));
        end
        repeat (3) cycle(1'b0, 1'b0, 0);
    endtask

    task automatic test_wrap_stamp();
        int s0;
        force dut.symbol_count = 16'hFFFE;
        #1;
        release dut.symbol_count;
        m_count = 16'hFFFE;
        s0 = sym_log.size();
        repeat (2 * SPS) pulse_err(4, 0, 0);
        checks++;
        if (sym_log.size() != s0 + 2 || sym_log[s0].cnt != 16'hFFFF || sym_log[s0+1].cnt != 0) begin
            failures++;
            $display("FAIL count_wrap: strobes=%0d, want 2 with counts ffff then 0000", sym_log.size() - s0);
        end
        checks++;
        if (sym_log.size() == s0 + 2 &&
            (sym_log[s0].stamp != sym_log[s0].want_stamp || sym_log[s0+1].stamp != sym_log[s0+1].want_stamp)) begin
            failures++;
            $display("FAIL pulse_stamp: got %h %h, want %h %h", sym_log[s0].stamp, sym_log[s0+1].stamp,
                     sym_log[s0].want_stamp, sym_log[s0+1].want_stamp);
        end
    endtask

    task automatic restart_check(input string name);
        int s0, nl, ne, base;
        s0 = sym_log.size(); nl = n_late; ne = n_early; base = p_idx;
        repeat (SPS) pulse_err(4, 0, 0);
        checks++;
        if (sym_log.size() != s0 + 1 || sym_log[sym_log.size()-1].pidx != base + SPS ||
            n_late != nl || n_early != ne) begin
            failures++;
            $display("FAIL %s_restart: strobes=%0d adjusts=%0d, want 1 strobe at pulse %0d and no adjust",
                     name, sym_log.size() - s0, (n_late - nl) + (n_early - ne), SPS);
        end
    endtask

    task automatic test_reset_mid_run();
        advance_to(1, 4);
        cycle(1'b0, 1'b1, 6000);
        advance_to(9, 4);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({symbol_strobe, mid_strobe, adj_early, adj_late, locked} !== 5'b0 || sample_phase !== '0 ||
            symbol_count !== '0 || pulse_stamp !== '0 || int'(dut.acc) != 0) begin
            failures++;
            $display("FAIL async_reset: ph=%0d cnt=%h stamp=%h acc=%0d, want all zero",
                     sample_phase, symbol_count, pulse_stamp, int'(dut.acc));
        end
        repeat (3) cycle(1'b0, 1'b0, 0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 0);
        restart_check("reset");
    endtask

    task automatic test_disable_mid_run();
        advance_to(1, 4);
        cycle(1'b0, 1'b1, 6000);
        advance_to(9, 4);
        enable = 1'b0;
        cycle(1'b0, 1'b0, 0);
        checks++;
        if (sample_phase !== '0 || int'(dut.acc) != 0) begin
            failures++;
            $display("FAIL disable_clear: ph=%0d acc=%0d, want 0 and 0", sample_phase, int'(dut.acc));
        end
        enable = 1'b1;
        cycle(1'b0, 1'b0, 0);
        restart_check("disable");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_late_adjust();
        test_early_adjust();
        test_saturation();
        test_wrap_stamp();
        test_reset_mid_run();
        test_disable_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qpsk_symbol_strobe.md
Name: qpsk_symbol_strobe

Overview:
- Downstream consumer of the CIC decimation pulse train (cic_40_pulse, one clk wide, nominally every 320 clk at 12.5 MHz) and the timing controller's cic_pulse_counter.
- Divides the CIC pulses into QPSK symbol periods and emits one-cycle symbol and mid-symbol strobes for the slicer and the Gardner detector.
- Nudges symbol phase by one CIC sample early or late from an accumulated timing error.
- Reports the symbol count and a lock flag.

Parameters:
- SPS, 16: CIC pulses per symbol; even, must be at least 4.
- ERR_W, 16: width of the signed timing error.
- ACC_W, 20: width of the signed error accumulator.
- THRESH, 4096: accumulator magnitude that triggers a phase adjust.
- LOCK_SYMS, 32: consecutive symbols without an adjust needed to assert lock.

Ports:
- clk  in  1  system clock (12.5 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run; when low, hold the block in its cleared state
- cic_40_pulse  in  1  one-cycle CIC output-sample strobe
- cic_pulse_counter  in  16  free-running pulse count from the timing controller; latched into pulse_stamp at each symbol strobe
- err_valid  in  1  timing error qualifier (single cycle)
- timing_err  in  ERR_W  signed error; positive means late
- symbol_strobe  out  1  one-cycle strobe at the symbol sample point
- mid_strobe  out  1  one-cycle strobe at half-symbol
- sample_phase  out  $clog2(SPS)  current phase, range 0..SPS-1
- symbol_count  out  16  number of symbols since enable
- pulse_stamp  out  16  cic_pulse_counter value captured at the last symbol strobe
- adj_early  out  1  one-cycle flag: advance applied
- adj_late  out  1  one-cycle flag: retard applied
- locked  out  1  lock indicator

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal state go to 0 (phase, accumulator, lock counter, strobes, flags, counts).
- enable low: synchronous clear of the same state on the next edge. Inputs are ignored.
- All state changes happen only on edges where enable=1. Strobes and adjust flags are otherwise 0.
- Phase advance on a cycle with cic_40_pulse=1:
  - Nominal: phase <= (phase+1) mod SPS.
  - Adjusts apply only on a pulse where phase==0 and an adjust is pending.
  - Late pending (acc >= THRESH): phase holds at 0, adj_late=1.
  - Early pending (acc <= -THRESH): phase <= 2, adj_early=1.
  - In both adjust cases the accumulator is cleared on that edge.
- Strobes are registered and high for exactly one cycle, on the edge of the qualifying pulse (1 clk latency from the pulse):
  - symbol_strobe = 1 when pulse && phase==SPS-1. On the same edge: symbol_count increments (wraps 0xFFFF to 0) and pulse_stamp <= cic_pulse_counter.
  - mid_strobe = 1 when pulse && phase==SPS/2-1.
  - A held phase 0 never produces a second symbol_strobe. An advance 0 to 2 never skips a strobe phase.
- Accumulator: on err_valid, acc <= sat(acc + sign-extended timing_err), saturating at the ACC_W signed limits.
  - If err_valid coincides with an adjust clear, acc <= timing_err (the clear wins, the new error is kept).
  - err_valid without a pulse is still accumulated.
- Lock:
  - The lock counter increments at each symbol_strobe that had no adjust in that symbol period. It saturates at LOCK_SYMS.
  - locked=1 when the counter equals LOCK_SYMS.
  - Any adj_early or adj_late clears the counter and drops locked on the same edge.
- A pulse coincident with enable rising is ignored. Counting starts with the next pulse.
- Mid-operation reset or disable aborts any pending adjust. No strobe is emitted on the following edge.

Test Plan:
- Nominal timing: rst_n low 400 clk, then high, enable=1, pulses every 320 clk, no errors. Required: first symbol_strobe on the 16th pulse edge, then every 5120 clk; mid_strobe on the 8th pulse and 5120 clk after; symbol_count 1,2,3…; locked rises at the 32nd strobe.
- Late adjust: inject err_valid with timing_err=+4096 once. Required: at the next pulse with phase==0, adj_late=1 and phase stays 0; that symbol period spans 17 pulses (5440 clk); locked drops and the lock counter restarts.
- Early adjust: inject timing_err=-2048 twice (acc=-4096). Required: adj_early=1 and phase 0 goes to 2; the next symbol_strobe comes 14 pulses later (4480 clk); no missed or duplicated strobe.
- Saturation and coincidence: inject 20 errors of +32767. Required: acc saturates at 524287. At adjust time, err_valid=1 with -100 on the same edge leaves acc=-100.
- Wrap and stamp: preload symbol_count to 0xFFFE. Required: strobes give 0xFFFF then 0x0000; pulse_stamp equals cic_pulse_counter sampled on each strobe edge.
- Reset and disable mid-run: assert rst_n low at phase 9 with an adjust pending. Required: all outputs 0 immediately; after release, the first strobe comes 16 pulses later. Dropping enable for one cycle gives the same result.
